// File: rtl/stream_program_loader_if.sv
// Byte-stream input and RAM write port of the boot-time program loader.
// master = loader side, slave = stream source / RAM side.
interface stream_program_loader_if #(
   parameter int WORD_SIZE     = 16,
   parameter int MEM_ADDR_SIZE = 8
);
   logic [7:0]               in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic [MEM_ADDR_SIZE-1:0] mem_addr;
   logic [WORD_SIZE-1:0]     mem_write_data;
   logic                     mem_write;

   modport master (
      input  in_data, in_valid,
      output in_ready, mem_addr, mem_write_data, mem_write
   );
   modport slave (
      output in_data, in_valid,
      input  in_ready, mem_addr, mem_write_data, mem_write
   );
endinterface

// File: rtl/stream_program_loader.sv
// Boot loader: word-count header, big-endian byte packing, one RAM write per word.
// Define LOADER_CHECKSUM_EN to require an XOR trailer word after the payload.
module stream_program_loader #(
   parameter int WORD_SIZE     = 16,
   parameter int MEM_ADDR_SIZE = 8,
   parameter int LOAD_BASE     = 0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start_load,
   stream_program_loader_if.master  bus,
   output logic                     load_complete,
   output logic                     load_error,
   output logic [MEM_ADDR_SIZE:0]   words_loaded
);
   localparam int BPW = WORD_SIZE / 8;
   localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
   // Header compare width: wide enough for both the header word and 2^MEM_ADDR_SIZE.
   localparam int CW  = (WORD_SIZE > MEM_ADDR_SIZE + 1) ? WORD_SIZE + 1 : MEM_ADDR_SIZE + 2;
   localparam logic [CW-1:0] DEPTH = CW'(1) << MEM_ADDR_SIZE;

   typedef enum logic [2:0] {
      IDLE, HEADER, DATA, WRITE,
`ifdef LOADER_CHECKSUM_EN
      CHECK,
`endif
      DONE, ERROR
   } state_t;

   state_t                 state;
   logic [WORD_SIZE-1:0]   asm_word, asm_next;
   logic [BW-1:0]          byte_cnt;
   logic [MEM_ADDR_SIZE:0] word_total;
   logic [CW-1:0]          hdr_ext;
   logic                   xfer, byte_last;
`ifdef LOADER_CHECKSUM_EN
   logic [WORD_SIZE-1:0]   csum;
`endif

   always_comb begin
      asm_next  = WORD_SIZE'({asm_word, bus.in_data});
      hdr_ext   = CW'(asm_next);
      xfer      = bus.in_valid & bus.in_ready;
      byte_last = (byte_cnt == BW'(BPW - 1));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state              <= IDLE;
         asm_word           <= '0;
         byte_cnt           <= '0;
         word_total         <= '0;
         bus.in_ready       <= 1'b0;
         bus.mem_addr       <= '0;
         bus.mem_write_data <= '0;
         bus.mem_write      <= 1'b0;
         load_complete      <= 1'b0;
         load_error         <= 1'b0;
         words_loaded       <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum               <= '0;
`endif
      end else begin
         bus.mem_write <= 1'b0;
         if (!start_load && state != IDLE) begin
            // Abort: partial word is dropped, status cleared.
            state         <= IDLE;
            bus.in_ready  <= 1'b0;
            byte_cnt      <= '0;
            load_complete <= 1'b0;
            load_error    <= 1'b0;
            words_loaded  <= '0;
         end else begin
            case (state)
               IDLE: if (start_load) begin
                  state        <= HEADER;
                  bus.in_ready <= 1'b1;
                  byte_cnt     <= '0;
                  words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                  csum         <= '0;
`endif
               end
               HEADER: if (xfer) begin
                  asm_word <= asm_next;
                  if (!byte_last) byte_cnt <= byte_cnt + 1'b1;
                  else begin
                     byte_cnt   <= '0;
                     word_total <= hdr_ext[MEM_ADDR_SIZE:0];
                     if (asm_next == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= CHECK;
`else
                        state         <= DONE;
                        bus.in_ready  <= 1'b0;
                        load_complete <= 1'b1;
`endif
                     end else if (hdr_ext > DEPTH) begin
                        state        <= ERROR;
                        bus.in_ready <= 1'b0;
                        load_error   <= 1'b1;
                     end else begin
                        state <= DATA;
                     end
                  end
               end
               DATA: if (xfer) begin
                  asm_word <= asm_next;
                  if (!byte_last) byte_cnt <= byte_cnt + 1'b1;
                  else begin
                     byte_cnt           <= '0;
                     state              <= WRITE;
                     bus.in_ready       <= 1'b0;
                     bus.mem_write      <= 1'b1;
                     bus.mem_addr       <= MEM_ADDR_SIZE'(LOAD_BASE + int'(words_loaded));
                     bus.mem_write_data <= asm_next;
                  end
               end
               WRITE: begin
                  words_loaded <= words_loaded + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  csum         <= csum ^ bus.mem_write_data;
`endif
                  if ((words_loaded + 1'b1) == word_total) begin
`ifdef LOADER_CHECKSUM_EN
                     state        <= CHECK;
                     bus.in_ready <= 1'b1;
`else
                     state         <= DONE;
                     load_complete <= 1'b1;
`endif
                  end else begin
                     state        <= DATA;
                     bus.in_ready <= 1'b1;
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               CHECK: if (xfer) begin
                  asm_word <= asm_next;
                  if (!byte_last) byte_cnt <= byte_cnt + 1'b1;
                  else begin
                     byte_cnt     <= '0;
                     bus.in_ready <= 1'b0;
                     if (asm_next == csum) begin
                        state         <= DONE;
                        load_complete <= 1'b1;
                     end else begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                     end
                  end
               end
`endif
               DONE, ERROR: ;
               default: begin
                  state        <= IDLE;
                  bus.in_ready <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_stream_program_loader.sv
// Randomized bench for stream_program_loader: two DUTs (LOAD_BASE 0 and 0xFF) share one stream.
module tb_stream_program_loader;
   localparam int WS = 16;
   localparam int AS = 8;

   logic          clock = 1'b0;
   logic          reset, start_load, in_valid;
   logic [7:0]    in_data;
   logic          lc0, le0, lc1, le1;
   logic [AS:0]   wl0, wl1;

   stream_program_loader_if #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS)) bus0 ();
   stream_program_loader_if #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS)) bus1 ();
   assign bus0.in_data  = in_data;
   assign bus0.in_valid = in_valid;
   assign bus1.in_data  = in_data;
   assign bus1.in_valid = in_valid;

   stream_program_loader #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS), .LOAD_BASE(0)) dut0 (
      .clock(clock), .reset(reset), .start_load(start_load), .bus(bus0),
      .load_complete(lc0), .load_error(le0), .words_loaded(wl0));
   stream_program_loader #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS), .LOAD_BASE(255)) dut1 (
      .clock(clock), .reset(reset), .start_load(start_load), .bus(bus1),
      .load_complete(lc1), .load_error(le1), .words_loaded(wl1));

   always #5 clock = ~clock;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      int            cyc;
      logic [AS-1:0] addr;
      logic [WS-1:0] data;
   } wr_t;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;
   int  acc[$];
   wr_t wr0[$], wr1[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Record accepted bytes and write strobes with their cycle numbers.
   always @(negedge clock) begin
      cyc <= cyc + 1;
      if (in_valid && bus0.in_ready) acc.push_back(cyc);
      if (bus0.mem_write) wr0.push_back('{cyc, bus0.mem_addr, bus0.mem_write_data});
      if (bus1.mem_write) wr1.push_back('{cyc, bus1.mem_addr, bus1.mem_write_data});
      check("excl", {31'd0, lc0 & le0}, 0);
      check("rdy_match", {31'd0, bus1.in_ready}, {31'd0, bus0.in_ready});
   end

   function automatic bq_t add_trailer(input bq_t s);
      logic [WS-1:0] x = '0;
      for (int i = 2; i + 1 < s.size(); i += 2) x ^= {s[i], s[i+1]};
      s.push_back(x[15:8]);
      s.push_back(x[7:0]);
      return s;
   endfunction

   function automatic bq_t payload_stream(input int n);
      bq_t s;
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      for (int i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
      s = add_trailer(s);
`endif
      return s;
   endfunction

   // abort_mode: 0 none, 1 drop start_load, 2 assert reset; after abort_after bytes.
   task automatic run_load(input bq_t s, input int gap, input int abort_mode, input int abort_after);
      int a0, w0b, w1b, idx, budget, endc, n, nw, nbytes, ws, exp_end, last;
      bit err;
      logic [WS-1:0] x;
      a0 = acc.size(); w0b = wr0.size(); w1b = wr1.size();
      idx = 0; budget = 0; endc = -1;
      start_load = 1'b1;
      while (endc < 0 && budget < 4000) begin
         in_valid = (idx < s.size()) && ($urandom_range(99) >= gap);
         in_data  = (idx < s.size()) ? s[idx] : 8'h00;
         @(negedge clock);
         if (in_valid && bus0.in_ready) idx++;
         if (lc0 || le0) endc = cyc;
         @(posedge clock); #1;
         budget++;
         if (abort_mode != 0 && idx == abort_after) break;
      end
      in_valid = 1'b0;

      if (abort_mode != 0) begin
         ws = wr0.size();
         if (abort_mode == 1) start_load = 1'b0; else reset = 1'b1;
         if (abort_mode == 1) @(posedge clock);
         @(negedge clock);
         check("abort_ready", {31'd0, bus0.in_ready}, 0);
         check("abort_lc",    {31'd0, lc0}, 0);
         check("abort_le",    {31'd0, le0}, 0);
         check("abort_wl",    32'(wl0), 0);
         repeat (3) @(negedge clock);
         check("abort_nowr",  wr0.size() - ws, 0);
         reset = 1'b0; start_load = 1'b0;
         @(posedge clock); #1;
         return;
      end

      check("done_seen", {31'd0, endc >= 0}, 1);
      // Keep offering bytes after completion; none may be taken.
      in_valid = 1'b1; in_data = 8'h5A;
      repeat (4) @(posedge clock);
      #1 in_valid = 1'b0;
      @(negedge clock);

      n = int'({s[0], s[1]});
      x = '0; err = 1'b0;
      if (n > 256) begin
         err = 1'b1; nw = 0; nbytes = 2;
      end else begin
         nw = n; nbytes = 2 + 2 * n;
         for (int k = 0; k < n; k++) x ^= {s[2+2*k], s[3+2*k]};
`ifdef LOADER_CHECKSUM_EN
         nbytes += 2;
         err = ({s[nbytes-2], s[nbytes-1]} != x);
`endif
      end
      check("accepted", acc.size() - a0, nbytes);
      check("nwrites0", wr0.size() - w0b, nw);
      check("nwrites1", wr1.size() - w1b, nw);
      for (int k = 0; k < nw && k < wr0.size() - w0b && k < wr1.size() - w1b; k++) begin
         check("wdata0", 32'(wr0[w0b+k].data), 32'({s[2+2*k], s[3+2*k]}));
         check("waddr0", 32'(wr0[w0b+k].addr), k % 256);
         check("wdata1", 32'(wr1[w1b+k].data), 32'({s[2+2*k], s[3+2*k]}));
         check("waddr1", 32'(wr1[w1b+k].addr), (255 + k) % 256);
         if (acc.size() - a0 == nbytes)
            check("wlat", wr0[w0b+k].cyc, acc[a0+3+2*k] + 1);
      end
      if (acc.size() - a0 == nbytes && wr0.size() - w0b == nw) begin
         last = acc[a0+nbytes-1];
`ifdef LOADER_CHECKSUM_EN
         exp_end = last + 1;
`else
         exp_end = (nw > 0) ? wr0[wr0.size()-1].cyc + 1 : last + 1;
`endif
         check("end_cycle", endc, exp_end);
      end
      check("lc0", {31'd0, lc0}, {31'd0, !err});
      check("le0", {31'd0, le0}, {31'd0, err});
      check("lc1", {31'd0, lc1}, {31'd0, !err});
      check("le1", {31'd0, le1}, {31'd0, err});
      check("wl0", 32'(wl0), nw);
      check("wl1", 32'(wl1), nw);
      check("ready_end", {31'd0, bus0.in_ready}, 0);

      start_load = 1'b0;
      @(posedge clock); @(negedge clock);
      check("clr_lc", {31'd0, lc0}, 0);
      check("clr_le", {31'd0, le0}, 0);
      check("clr_wl", 32'(wl0), 0);
      @(posedge clock); #1;
   endtask

   initial begin
      bq_t s;
      reset = 1'b1; start_load = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) @(negedge clock);
      check("rst_ready", {31'd0, bus0.in_ready}, 0);
      check("rst_wr",    {31'd0, bus0.mem_write}, 0);
      check("rst_addr",  32'(bus1.mem_addr), 0);
      check("rst_data",  32'(bus0.mem_write_data), 0);
      check("rst_lc",    {31'd0, lc0 | lc1}, 0);
      check("rst_le",    {31'd0, le0 | le1}, 0);
      check("rst_wl",    32'(wl0 | wl1), 0);
      @(posedge clock); #1 reset = 1'b0;
      @(posedge clock); #1;

      s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
      s = add_trailer(s);
`endif
      run_load(s, 0, 0, 0);
      run_load(s, 40, 0, 0);
      s = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
      s = add_trailer(s);
`endif
      run_load(s, 0, 0, 0);
      s = '{8'h01, 8'h01, 8'hAA, 8'hBB};
      run_load(s, 0, 0, 0);
      s = '{8'h00, 8'h03, 8'h12};
      run_load(s, 0, 1, 3);
      run_load(payload_stream(3), 20, 0, 0);
      run_load(payload_stream(2), 0, 2, 5);
      run_load(payload_stream(256), 0, 0, 0);
`ifdef LOADER_CHECKSUM_EN
      s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hB9, 8'hF8};
      run_load(s, 0, 0, 0);
`endif
      for (int t = 0; t < 10; t++) run_load(payload_stream(int'($urandom_range(6))), int'($urandom_range(60)), 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
